mem_stack_ctrl: RTL and testbench

MEM_STACK_CTRL -- requirements
Module: mem_stack_ctrl

---
 rtl/calcutec_pkg.sv | 22 ++
 rtl/mem_stack_ctrl.sv | 137 +++++++++++++
 tb/tb_mem_stack_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/calcutec_pkg.sv
// Shared encodings and default widths for the stack controller and its neighbours.
package calcutec_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_PUSH  = 2'b00,
        OP_POP   = 2'b01,
        OP_PEEK  = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

endpackage

// File: rtl/mem_stack_ctrl.sv
// Hardware stack controller that keeps its words in an external registered-read memory.
// One command is in flight at a time; each completes with a single rsp_valid pulse.
module mem_stack_ctrl
    import calcutec_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              mem_oe,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] SP_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W:0]     sp_q;
    op_t                 op_p0;
    logic [DATA_W-1:0]   operand_p0;
    logic                err_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                accept;
    logic                is_read_op;
    logic [ADDR_W-1:0]   top_addr;

    assign full       = (sp_q == CAPACITY);
    assign empty      = (sp_q == '0);
    assign accept     = cmd_valid && cmd_ready;
    assign is_read_op = (op_t'(cmd_op) == OP_POP) || (op_t'(cmd_op) == OP_PEEK);
    assign top_addr   = ADDR_W'(sp_q - SP_ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        mem_we      = 1'b0;
        mem_oe      = 1'b0;
        mem_address = '0;
        mem_data    = '0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (op_t'(cmd_op) == OP_PUSH && !full) begin
                        state_d = ST_WRITE;
                    end else if (is_read_op && !empty) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WRITE: begin
                mem_we      = 1'b1;
                mem_address = sp_q[ADDR_W-1:0];
                mem_data    = operand_p0;
                state_d     = ST_RESP;
            end
            ST_READ: begin
                mem_oe      = 1'b1;
                mem_address = top_addr;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stage p0: command capture at the accept edge
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0      <= op_t'(cmd_op);
            operand_p0 <= cmd_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q       <= '0;
            err_q      <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                rsp_data_q <= '0;
                err_q      <= (op_t'(cmd_op) == OP_PUSH && full) || (is_read_op && empty);
                if (op_t'(cmd_op) == OP_CLEAR) begin
                    sp_q <= '0;
                end
            end
            if (state_q == ST_WRITE) begin
                sp_q <= sp_q + SP_ONE;
            end
            // Read data arrives the cycle after the oe strobe
            if (state_q == ST_WAIT) begin
                rsp_data_q <= mem_rdata;
                if (op_p0 == OP_POP) begin
                    sp_q <= sp_q - SP_ONE;
                end
            end
        end
    end

    assign rsp_err  = rsp_valid && err_q;
    assign rsp_data = rsp_valid ? rsp_data_q : '0;

endmodule

// File: tb/tb_mem_stack_ctrl.sv
// Bench for mem_stack_ctrl: a queue-based stack model plus a registered-read memory beside the DUT.
module tb_mem_stack_ctrl;
    import calcutec_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          full;
    logic          empty;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_we;
    logic          mem_oe;
    logic [DW-1:0] mem_rdata;

    int total = 0;
    int bad   = 0;
    int cmd_idx = 0;

    int we_cnt = 0;
    int oe_cnt = 0;
    int overlap_cnt = 0;
    int idle_bad = 0;
    logic [AW-1:0] we_addr;
    logic [DW-1:0] we_data;
    logic [AW-1:0] oe_addr;

    logic [DW-1:0] model[$];
    logic [DW-1:0] mem [CAP];

    always #5 clk = ~clk;

    mem_stack_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .full(full), .empty(empty),
        .mem_address(mem_address), .mem_data(mem_data),
        .mem_we(mem_we), .mem_oe(mem_oe), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_address] <= mem_data;
        if (mem_oe) mem_rdata <= mem[mem_address];
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                we_cnt  = we_cnt + 1;
                we_addr = mem_address;
                we_data = mem_data;
            end
            if (mem_oe) begin
                oe_cnt  = oe_cnt + 1;
                oe_addr = mem_address;
            end
            if (mem_we && mem_oe) overlap_cnt = overlap_cnt + 1;
            if (!mem_we && !mem_oe && (mem_address != '0 || mem_data != '0)) idle_bad = idle_bad + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [DW-1:0] d);
        int n;
        int e_lat;
        int lat;
        int we0, oe0, ov0;
        logic e_err, e_we, e_oe, seen, got_err;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data, got_data;
        string p;
        n = model.size();
        e_lat = 1; e_err = 1'b0; e_we = 1'b0; e_oe = 1'b0; e_addr = '0; e_data = '0;
        case (op)
            OP_PUSH: if (n == CAP) e_err = 1'b1;
                     else begin e_lat = 2; e_we = 1'b1; e_addr = AW'(n); end
            OP_POP, OP_PEEK: if (n == 0) e_err = 1'b1;
                     else begin e_lat = 3; e_oe = 1'b1; e_addr = AW'(n - 1); e_data = model[n-1]; end
            default: e_lat = 1;
        endcase
        p = $sformatf("cmd%0d_op%0d", cmd_idx, op);
        cmd_idx = cmd_idx + 1;

        lat = 0;
        while (!cmd_ready && lat < 20) begin @(negedge clk); lat = lat + 1; end
        check({p, "_ready"}, 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = $urandom;
        we0 = we_cnt; oe0 = oe_cnt; ov0 = overlap_cnt;

        lat = 0; seen = 1'b0; got_err = 1'b0; got_data = '0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat = lat + 1;
            if (rsp_valid) begin seen = 1'b1; got_err = rsp_err; got_data = rsp_data; end
        end
        @(posedge clk); #1;

        check({p, "_latency"}, 64'(lat), 64'(e_lat));
        check({p, "_err"}, 64'(got_err), 64'(e_err));
        check({p, "_data"}, 64'(got_data), 64'(e_data));
        check({p, "_we_count"}, 64'(we_cnt - we0), 64'(e_we));
        check({p, "_oe_count"}, 64'(oe_cnt - oe0), 64'(e_oe));
        check({p, "_we_oe_overlap"}, 64'(overlap_cnt - ov0), 64'(0));
        if (e_we) begin
            check({p, "_we_addr"}, 64'(we_addr), 64'(e_addr));
            check({p, "_we_data"}, 64'(we_data), 64'(d));
        end
        if (e_oe) check({p, "_oe_addr"}, 64'(oe_addr), 64'(e_addr));
        check({p, "_rsp_one_cycle"}, 64'(rsp_valid), 64'(0));

        case (op)
            OP_PUSH:  if (n < CAP) model.push_back(d);
            OP_POP:   if (n > 0) void'(model.pop_back());
            OP_CLEAR: model.delete();
            default:  ;
        endcase
        check({p, "_empty"}, 64'(empty), 64'(model.size() == 0));
        check({p, "_full"}, 64'(full), 64'(model.size() == CAP));
    endtask

    initial begin
        int rcnt;
        int r;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_mem_oe", 64'(mem_oe), 64'(0));
        check("rst_mem_address", 64'(mem_address), 64'(0));
        check("rst_mem_data", 64'(mem_data), 64'(0));
        check("rst_empty", 64'(empty), 64'(1));
        check("rst_full", 64'(full), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        run_cmd(OP_POP, '0);
        run_cmd(OP_PUSH, 32'd1);
        run_cmd(OP_PUSH, 32'd10);
        run_cmd(OP_PUSH, 32'd100);
        repeat (3) run_cmd(OP_POP, '0);

        run_cmd(OP_PUSH, 32'd102);
        run_cmd(OP_PEEK, '0);
        run_cmd(OP_PEEK, '0);
        run_cmd(OP_CLEAR, '0);

        run_cmd(OP_PUSH, 32'd5);
        run_cmd(OP_CLEAR, '0);
        run_cmd(OP_POP, '0);

        for (int i = 0; i < CAP; i++) run_cmd(OP_PUSH, $urandom);
        run_cmd(OP_PUSH, 32'hDEAD);
        run_cmd(OP_PEEK, '0);
        run_cmd(OP_POP, '0);
        run_cmd(OP_PUSH, 32'hBEEF);
        run_cmd(OP_PUSH, 32'hCAFE);
        run_cmd(OP_CLEAR, '0);

        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(99, 0));
            if (r < 45)      run_cmd(OP_PUSH, $urandom);
            else if (r < 75) run_cmd(OP_POP, '0);
            else if (r < 93) run_cmd(OP_PEEK, '0);
            else             run_cmd(OP_CLEAR, '0);
        end

        run_cmd(OP_PUSH, 32'h77);
        cmd_valid = 1'b1; cmd_op = OP_POP; cmd_data = '0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("abort_read_oe", 64'(mem_oe), 64'(1));
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_cmd_ready", 64'(cmd_ready), 64'(1));
        check("abort_empty", 64'(empty), 64'(1));
        check("abort_rsp_valid", 64'(rsp_valid), 64'(0));
        #1 reset = 1'b0;
        model.delete();
        rcnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) rcnt = rcnt + 1;
        end
        check("abort_no_response", 64'(rcnt), 64'(0));
        run_cmd(OP_PUSH, 32'hABCD);
        run_cmd(OP_POP, '0);

        check("idle_bus_zero", 64'(idle_bad), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
